word_serializer: RTL and testbench
==================================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the input word FIFO depth (power of two, minimum 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning byte order: 1 emits bits [31:24] first, 0 emits bits [7:0] first.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_in_i, input, 32 bits: the word from the upstream dummy stage (its data_out_o).
REQ-006 The block SHALL have port data_valid_i, input, 1 bit: data_in_i holds a word to accept.
REQ-007 The block SHALL have port data_ready_o, output, 1 bit: the FIFO can accept a word this cycle.
REQ-008 The block SHALL have port byte_o, output, 8 bits: the current serialized byte.
REQ-009 The block SHALL have port byte_valid_o, output, 1 bit: byte_o is valid.
REQ-010 The block SHALL have port byte_ready_i, input, 1 bit: the downstream consumer accepts byte_o.
REQ-011 The block SHALL have port byte_last_o, output, 1 bit: byte_o is the fourth byte of its word.
REQ-012 The block SHALL have port fill_o, output, $clog2(DEPTH)+1 bits: the number of words held in the FIFO, excluding the word being shifted.

Function
REQ-013 A word SHALL be accepted on a rising edge where data_valid_i=1 and data_ready_o=1, and no other.
REQ-014 data_ready_o SHALL equal (fill_o != DEPTH); a push into a full FIFO SHALL NOT occur, even on a pop cycle.
REQ-015 The FIFO SHALL be first-in first-out; pointers SHALL wrap modulo DEPTH.
REQ-016 A simultaneous push and pop SHALL leave fill_o unchanged.
REQ-017 The serializer FSM SHALL have states IDLE (no word loaded) and SHIFT (a word is loaded, with a 2-bit byte index idx of 0..3).
REQ-018 In IDLE with fill_o>0, the FSM SHALL pop the head word into a 32-bit shift register on the next edge, set idx=0 and go to SHIFT.
REQ-019 byte_valid_o SHALL be 1 exactly when the FSM is in SHIFT.
REQ-020 A word accepted at edge N into an empty, idle block SHALL appear in FIFO at N, load at N+1, and present byte_valid_o=1 after edge N+1.
REQ-021 A byte SHALL be consumed on an edge with byte_valid_o=1 and byte_ready_i=1; idx SHALL then increment.
REQ-022 byte_o and byte_valid_o SHALL stay stable while byte_valid_o=1 and byte_ready_i=0.
REQ-023 byte_last_o SHALL equal (idx==3) while in SHIFT, and SHALL be 0 in IDLE.
REQ-024 When the idx==3 byte is consumed, the FSM SHALL load the next FIFO word on the same edge (idx=0, stay in SHIFT) if fill_o>0, otherwise go to IDLE; sustained throughput SHALL be one byte per cycle with no bubble between words.
REQ-025 A word shall be carried unmodified, including X/Z bits; the block SHALL NOT filter or check the word contents.

Reset
REQ-026 While reset_i=1, the block SHALL immediately force FIFO empty (fill_o=0), FSM=IDLE, idx=0, byte_valid_o=0, byte_last_o=0, byte_o=8'h00 and data_ready_o=1, with no clock required.
REQ-027 A reset asserted mid-word or mid-burst SHALL discard the partially sent word and all queued words; no byte from them SHALL appear after reset is released.
REQ-028 Words SHALL be accepted on the first rising edge after reset_i falls.

Structure
REQ-029 The package word_serializer_pkg SHALL hold the FSM state typedef (IDLE, SHIFT), BYTES_PER_WORD=4 and BYTE_W=8.
REQ-030 The FIFO SHALL be one sub-module, sync_fifo, with parameters WIDTH and DEPTH, push/pop/full/empty/count ports, and the same clock and reset.

Verification
REQ-031 Single word: push 32'h12345678 with byte_ready_i=1 and MSB_FIRST=1 -> bytes 12,34,56,78 on four consecutive cycles, byte_last_o only with 78, first byte after edge N+1.
REQ-032 Back-to-back: push 32'hA1A2A3A4 and then 32'hB1B2B3B4 with byte_ready_i=1 -> eight consecutive valid cycles with no gap; byte_last_o on A4 and B4.
REQ-033 Full/backpressure: byte_ready_i=0, push DEPTH+1 words -> fill_o=DEPTH and data_ready_o=0 after the DEPTH+1th load; release byte_ready_i -> all words emitted in order, none lost or duplicated.
REQ-034 Stall stability: toggle byte_ready_i pseudo-randomly during 32'hDEADBEEF -> byte_o holds on each stall; output sequence DE,AD,BE,EF.
REQ-035 Reset mid-word: assert reset_i for 1.3 clock periods after the second byte of 32'h12345678 -> outputs go to their reset values at once; after release the next pushed word 32'h0 yields 00,00,00,00 only.
REQ-036 X pass-through and order: push 32'hx then 32'h12345678 with MSB_FIRST=0 -> four X bytes, then 78,56,34,12.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared types and constants for the word serializer
package word_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_serializer_if.sv
// rtl/word_serializer_if.sv - word-in / byte-out handshake bundle
interface word_serializer_if #(
    parameter int DEPTH = 4
) ();
    import word_serializer_pkg::*;

    logic [WORD_W-1:0]       data_in;
    logic                    data_valid;
    logic                    data_ready;
    logic [BYTE_W-1:0]       byte_data;
    logic                    byte_valid;
    logic                    byte_ready;
    logic                    byte_last;
    logic [$clog2(DEPTH):0]  fill;

    // master drives words in and consumes bytes; slave is the serializer side
    modport master (
        output data_in, data_valid, byte_ready,
        input  data_ready, byte_data, byte_valid, byte_last, fill
    );

    modport slave (
        input  data_in, data_valid, byte_ready,
        output data_ready, byte_data, byte_valid, byte_last, fill
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, async active-high reset
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // a full FIFO refuses pushes even when a pop happens on the same edge
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - buffers 32-bit words and emits them one byte per cycle
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [WORD_W-1:0]       data_in_i,
    input  logic                    data_valid_i,
    output logic                    data_ready_o,
    output logic [BYTE_W-1:0]       byte_o,
    output logic                    byte_valid_o,
    input  logic                    byte_ready_i,
    output logic                    byte_last_o,
    output logic [$clog2(DEPTH):0]  fill_o
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty, pop;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (data_valid_i),
        .wdata_i (data_in_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill_o)
    );

    assign data_ready_o = !fifo_full;
    assign byte_valid_o = valid_q;
    assign byte_last_o  = last_q;
    // the current byte always sits at the outgoing end of the shift register
    assign byte_o       = MSB_FIRST ? sr_q[WORD_W-1 -: BYTE_W] : sr_q[BYTE_W-1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sr_d    = fifo_rdata;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (byte_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        // reload on the same edge so consecutive words have no bubble
                        if (!fifo_empty) begin
                            pop   = 1'b1;
                            sr_d  = fifo_rdata;
                        end else begin
                            sr_d    = '0;
                            state_d = IDLE;
                        end
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        sr_d  = MSB_FIRST ? (sr_q << BYTE_W) : (sr_q >> BYTE_W);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == SHIFT);
        last_d  = (state_d == SHIFT) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sr_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - self-checking bench for word_serializer
module tb_word_serializer;
    import word_serializer_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    word_serializer_if #(.DEPTH(DEPTH)) bus ();

    word_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .data_in_i    (bus.data_in),
        .data_valid_i (bus.data_valid),
        .data_ready_o (bus.data_ready),
        .byte_o       (bus.byte_data),
        .byte_valid_o (bus.byte_valid),
        .byte_ready_i (bus.byte_ready),
        .byte_last_o  (bus.byte_last),
        .fill_o       (bus.fill)
    );

    logic [31:0] l_data   = '0;
    logic        l_valid  = 1'b0;
    logic        l_bready = 1'b0;
    logic        l_ready, l_bvalid, l_last;
    logic [7:0]  l_byte;
    logic [2:0]  l_fill;

    word_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i        (clk),
        .reset_i      (reset),
        .data_in_i    (l_data),
        .data_valid_i (l_valid),
        .data_ready_o (l_ready),
        .byte_o       (l_byte),
        .byte_valid_o (l_bvalid),
        .byte_ready_i (l_bready),
        .byte_last_o  (l_last),
        .fill_o       (l_fill)
    );

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  bytes [4];
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    logic stalled = 1'b0;
    logic [7:0] held_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_exp(input logic [31:0] w);
        for (int i = 0; i < 4; i++) sb.push_back('{w[31-8*i -: 8], i == 3});
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || bus.byte_valid) && k < 200) begin
            tick();
            k++;
        end
        tests++;
        if (k >= 200) begin
            fails++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check("stall_hold", {23'd0, bus.byte_valid, bus.byte_data}, {23'd0, 1'b1, held_b});
            if (bus.byte_valid && bus.byte_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %h expected none", bus.byte_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_byte", {24'd0, bus.byte_data}, {24'd0, e.b});
                    check("sb_last", {31'd0, bus.byte_last}, {31'd0, e.last});
                end
            end
            stalled = bus.byte_valid && !bus.byte_ready;
            held_b  = bus.byte_data;
        end
    end

    initial begin
        vec_t tbl [5];
        logic [31:0] xw;
        logic [7:0]  lsb_exp [4];
        int n_before;

        tbl[0] = '{32'h01020304, '{8'h01, 8'h02, 8'h03, 8'h04}};
        tbl[1] = '{32'hCAFEF00D, '{8'hCA, 8'hFE, 8'hF0, 8'h0D}};
        tbl[2] = '{32'hFF00FF00, '{8'hFF, 8'h00, 8'hFF, 8'h00}};
        tbl[3] = '{32'h80000001, '{8'h80, 8'h00, 8'h00, 8'h01}};
        tbl[4] = '{32'h0F1E2D3C, '{8'h0F, 8'h1E, 8'h2D, 8'h3C}};
        lsb_exp = '{8'h78, 8'h56, 8'h34, 8'h12};
        xw = 32'hxxxxxxxx;

        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.byte_ready = 1'b0;

        // reset values must appear with no clock edge yet
        #1;
        check("rst_fill", {29'd0, bus.fill}, 32'd0);
        check("rst_ready", {31'd0, bus.data_ready}, 32'd1);
        check("rst_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("rst_last", {31'd0, bus.byte_last}, 32'd0);
        check("rst_byte", {24'd0, bus.byte_data}, 32'd0);
        repeat (2) tick();

        // single word, accepted on the first edge after reset release
        reset = 1'b0;
        bus.data_in = 32'h12345678;
        bus.data_valid = 1'b1;
        bus.byte_ready = 1'b1;
        add_exp(32'h12345678);
        tick();
        bus.data_valid = 1'b0;
        check("single_fill_n", {29'd0, bus.fill}, 32'd1);
        check("single_valid_n", {31'd0, bus.byte_valid}, 32'd0);
        tick();
        check("single_fill_n1", {29'd0, bus.fill}, 32'd0);
        check("single_first", {24'd0, bus.byte_data}, 32'h12);
        for (int i = 0; i < 4; i++) begin
            check("single_valid", {31'd0, bus.byte_valid}, 32'd1);
            tick();
        end
        check("single_done", {31'd0, bus.byte_valid}, 32'd0);

        // back-to-back words with no gap
        bus.data_in = 32'hA1A2A3A4;
        bus.data_valid = 1'b1;
        add_exp(32'hA1A2A3A4);
        tick();
        bus.data_in = 32'hB1B2B3B4;
        add_exp(32'hB1B2B3B4);
        tick();
        bus.data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("b2b_valid", {31'd0, bus.byte_valid}, 32'd1);
            tick();
        end
        check("b2b_done", {31'd0, bus.byte_valid}, 32'd0);

        // table words under backpressure until the FIFO fills
        bus.byte_ready = 1'b0;
        bus.data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.data_in = tbl[i].word;
            for (int j = 0; j < 4; j++) sb.push_back('{tbl[i].bytes[j], j == 3});
            tick();
        end
        bus.data_in = 32'h99999999;
        check("full_fill", {29'd0, bus.fill}, DEPTH);
        check("full_ready", {31'd0, bus.data_ready}, 32'd0);
        tick();
        bus.data_valid = 1'b0;
        check("full_no_push", {29'd0, bus.fill}, DEPTH);
        check("full_head", {24'd0, bus.byte_data}, 32'h01);
        bus.byte_ready = 1'b1;
        drain("full");
        check("full_empty", {29'd0, bus.fill}, 32'd0);

        // random stalls during one word
        bus.data_in = 32'hDEADBEEF;
        bus.data_valid = 1'b1;
        add_exp(32'hDEADBEEF);
        bus.byte_ready = 1'b0;
        tick();
        bus.data_valid = 1'b0;
        for (int k = 0; k < 100 && (sb.size() != 0 || bus.byte_valid); k++) begin
            tick();
            bus.byte_ready = 1'($urandom_range(0, 1));
        end
        bus.byte_ready = 1'b1;
        drain("stall");

        // reset after the second byte has gone out
        bus.data_in = 32'h12345678;
        bus.data_valid = 1'b1;
        sb.push_back('{8'h12, 1'b0});
        sb.push_back('{8'h34, 1'b0});
        tick();
        bus.data_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("mid_rst_byte", {24'd0, bus.byte_data}, 32'd0);
        check("mid_rst_last", {31'd0, bus.byte_last}, 32'd0);
        check("mid_rst_fill", {29'd0, bus.fill}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.data_ready}, 32'd1);
        check("mid_rst_sb", sb.size(), 32'd0);
        #12;
        reset = 1'b0;
        n_before = n_out;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_idle", {31'd0, bus.byte_valid}, 32'd0);
        end
        bus.data_in = 32'h0;
        bus.data_valid = 1'b1;
        add_exp(32'h0);
        tick();
        bus.data_valid = 1'b0;
        drain("post_rst");
        repeat (3) tick();
        check("post_rst_count", n_out - n_before, 32'd4);

        // LSB-first instance: unknown word then a known one
        l_bready = 1'b1;
        l_valid  = 1'b1;
        l_data   = xw;
        tick();
        l_data = 32'h12345678;
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lsb_valid", {31'd0, l_bvalid}, 32'd1);
            if (i < 4) check("lsb_x_byte", {24'd0, l_byte}, {24'd0, xw[8*i +: 8]});
            else       check("lsb_byte", {24'd0, l_byte}, {24'd0, lsb_exp[i-4]});
            check("lsb_last", {31'd0, l_last}, {31'd0, (i % 4) == 3});
            tick();
        end
        check("lsb_done", {31'd0, l_bvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
